// File: rtl/fir_ntap_stream_if.sv
// Stream, coefficient and control signals of the N-tap FIR filter.
// The DUT side connects through the slave modport, the sample source through master.
interface fir_ntap_stream_if #(
  parameter int NTAPS = 4,
  parameter int DW    = 8,
  parameter int CW    = 8,
  parameter int OUTW  = DW + CW + $clog2(NTAPS)
);
  localparam int AW = (NTAPS > 1) ? $clog2(NTAPS) : 1;

  logic            Xin_valid;
  logic            Xin_ready;
  logic [DW-1:0]   Xin;
  logic            Yout_valid;
  logic            Yout_ready;
  logic [OUTW-1:0] Yout;
  logic            Sat;
  logic            coef_we;
  logic [AW-1:0]   coef_addr;
  logic [CW-1:0]   coef_data;
  logic            coef_commit;
  logic            flush;

  modport master (
    output Xin_valid, Xin, Yout_ready, coef_we, coef_addr, coef_data, coef_commit, flush,
    input  Xin_ready, Yout_valid, Yout, Sat
  );

  modport slave (
    input  Xin_valid, Xin, Yout_ready, coef_we, coef_addr, coef_data, coef_commit, flush,
    output Xin_ready, Yout_valid, Yout, Sat
  );
endinterface

// File: rtl/fir_ntap_stream.sv
// Signed direct-form FIR, NTAPS taps, valid/ready streaming with a one-cycle
// registered output. Coefficients are double-buffered: per-tap writes go to a
// shadow bank, coef_commit copies the whole shadow bank into the active bank.
// Full-precision accumulate, then optional round-half-up shift and saturation.
module fir_ntap_stream #(
  parameter int NTAPS     = 4,
  parameter int DW        = 8,
  parameter int CW        = 8,
  parameter int ACCW      = DW + CW + $clog2(NTAPS),
  parameter int OUT_SHIFT = 0,
  parameter int OUTW      = ACCW
) (
  input logic                Clk,
  input logic                Rst_n,
  fir_ntap_stream_if.slave   bus
);
  localparam int PW = DW + CW;

  localparam logic [ACCW:0]        ONE_SH = (ACCW + 1)'(1) << OUT_SHIFT;
  localparam logic signed [ACCW:0] HALF   = $signed(ONE_SH >> 1);
  localparam logic signed [ACCW:0] MAXV   = $signed({{(ACCW + 2 - OUTW){1'b0}}, {(OUTW - 1){1'b1}}});
  localparam logic signed [ACCW:0] MINV   = ~MAXV;
  localparam logic [OUTW-1:0]      YMAX   = {1'b0, {(OUTW - 1){1'b1}}};
  localparam logic [OUTW-1:0]      YMIN   = {1'b1, {(OUTW - 1){1'b0}}};

  logic signed [DW-1:0] hist        [NTAPS-1];
  logic signed [CW-1:0] shadow      [NTAPS];
  logic signed [CW-1:0] shadow_next [NTAPS];
  logic signed [CW-1:0] active      [NTAPS];

  logic                   xin_ready;
  logic                   accept;
  logic signed [ACCW-1:0] acc;
  logic signed [ACCW:0]   rnd;
  logic signed [ACCW:0]   r;
  logic [OUTW-1:0]        y_next;
  logic                   sat_next;
  logic                   yout_valid_q;
  logic [OUTW-1:0]        yout_q;
  logic                   sat_q;

  function automatic logic signed [PW-1:0] mul(input logic signed [DW-1:0] x,
                                               input logic signed [CW-1:0] c);
    return PW'(x) * PW'(c);
  endfunction

  assign xin_ready      = ~bus.flush & (~yout_valid_q | bus.Yout_ready);
  assign accept         = bus.Xin_valid & xin_ready;
  assign bus.Xin_ready  = xin_ready;
  assign bus.Yout_valid = yout_valid_q;
  assign bus.Yout       = yout_q;
  assign bus.Sat        = sat_q;

  // Shadow bank after this cycle's write, so a same-cycle commit sees the write.
  always_comb begin
    shadow_next = shadow;
    if (bus.coef_we && (int'(bus.coef_addr) < NTAPS))
      shadow_next[bus.coef_addr] = $signed(bus.coef_data);
  end

  // Full-precision dot product of incoming sample + history with the active bank.
  always_comb begin
    acc = ACCW'(mul($signed(bus.Xin), active[0]));
    for (int unsigned k = 1; k < NTAPS; k++)
      acc = acc + ACCW'(mul(hist[k-1], active[k]));
  end

  // Round half up, arithmetic shift, then clamp into the output range.
  always_comb begin
    rnd      = (ACCW + 1)'(acc) + HALF;
    r        = rnd >>> OUT_SHIFT;
    y_next   = r[OUTW-1:0];
    sat_next = 1'b0;
    if (r > MAXV) begin
      y_next   = YMAX;
      sat_next = 1'b1;
    end else if (r < MINV) begin
      y_next   = YMIN;
      sat_next = 1'b1;
    end
  end

  // Coefficient banks: shadow takes writes, active loads the whole shadow on commit.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      shadow <= '{default: '0};
      active <= '{default: '0};
    end else begin
      shadow <= shadow_next;
      if (bus.coef_commit)
        active <= shadow_next;
    end
  end

  // Sample history: cleared by flush, shifted on every accepted sample.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      hist <= '{default: '0};
    end else if (bus.flush) begin
      hist <= '{default: '0};
    end else if (accept) begin
      hist[0] <= $signed(bus.Xin);
      for (int unsigned k = 1; k < NTAPS - 1; k++)
        hist[k] <= hist[k-1];
    end
  end

  // Output register: loads on accept, drops valid on a transfer with no new sample.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      yout_valid_q <= 1'b0;
      yout_q       <= '0;
      sat_q        <= 1'b0;
    end else if (accept) begin
      yout_valid_q <= 1'b1;
      yout_q       <= y_next;
      sat_q        <= sat_next;
    end else if (yout_valid_q && bus.Yout_ready) begin
      yout_valid_q <= 1'b0;
    end
  end
endmodule
